// File: rtl/prbs_checker.sv
// Far-end PRBS checker: seeds a local copy of the upstream lfsr sequence from
// the received words, declares lock after a clean run and counts word errors.
module prbs_checker #(
   parameter int               WIDTH         = 32,
   parameter logic [WIDTH-1:0] TAP           = 32'h80000032,
   parameter int               LOCK_COUNT    = 4,
   parameter int               LOSS_COUNT    = 4,
   parameter int               ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     clear,
   output logic                     locked,
   output logic                     err,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int BAD_W  = $clog2(LOSS_COUNT + 1);
   localparam logic [GOOD_W-1:0] LOCK_THR = GOOD_W'(LOCK_COUNT);
   localparam logic [BAD_W-1:0]  LOSS_THR = BAD_W'(LOSS_COUNT);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                   state_q;
   logic [WIDTH-1:0]         exp_q;
   logic [GOOD_W-1:0]        good_q;
   logic [BAD_W-1:0]         bad_q;
   logic                     locked_q;
   logic                     err_q;
   logic [ERR_CNT_WIDTH-1:0] cnt_q;

   logic [GOOD_W-1:0]        good_d;
   logic [BAD_W-1:0]         bad_d;
   logic [ERR_CNT_WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0]         seed_d;
   logic [WIDTH-1:0]         exp_d;
   logic                     match;
   logic                     data_zero;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
      return {x[WIDTH-2:0], ^(x & TAP)};
   endfunction

   always_comb begin
      good_d    = good_q + GOOD_W'(1);
      bad_d     = bad_q + BAD_W'(1);
      cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + ERR_CNT_WIDTH'(1);
      seed_d    = step(in_data);
      exp_d     = step(exp_q);
      match     = (in_data == exp_q);
      data_zero = (in_data == '0);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= ST_SEARCH;
         exp_q    <= '0;
         good_q   <= '0;
         bad_q    <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         err_q <= 1'b0;
         if (in_valid) begin
            case (state_q)
               ST_SEARCH: begin
                  // An all-zero word is the lfsr lockup value and cannot seed.
                  if (!data_zero) begin
                     exp_q   <= seed_d;
                     good_q  <= '0;
                     state_q <= ST_VERIFY;
                  end
               end
               ST_VERIFY: begin
                  if (match) begin
                     exp_q  <= exp_d;
                     good_q <= good_d;
                     if (good_d == LOCK_THR) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        bad_q    <= '0;
                     end
                  end else if (!data_zero) begin
                     exp_q  <= seed_d;
                     good_q <= '0;
                  end else begin
                     state_q <= ST_SEARCH;
                  end
               end
               ST_LOCKED: begin
                  // Flywheel: the expected word advances regardless of errors.
                  exp_q <= exp_d;
                  if (match) begin
                     bad_q <= '0;
                  end else begin
                     err_q <= 1'b1;
                     cnt_q <= cnt_d;
                     bad_q <= bad_d;
                     if (bad_d == LOSS_THR) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        good_q   <= '0;
                     end
                  end
               end
               default: begin
                  state_q  <= ST_SEARCH;
                  locked_q <= 1'b0;
               end
            endcase
         end
         // Placed last so a clear overrides a same-cycle increment.
         if (clear) begin
            cnt_q <= '0;
         end
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock/unlock, flywheel, error counting,
// saturation on a narrow counter instance and asynchronous reset.
module tb_prbs_checker;

   localparam logic [31:0] TAP  = 32'h80000032;
   localparam logic [31:0] SEED = 32'h000086E6;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        clear;
   logic        locked;
   logic        err;
   logic [15:0] err_count;
   logic        locked_s;
   logic        err_s;
   logic [3:0]  err_count_s;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] x;

   always #5 clk = ~clk;

   prbs_checker dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clear     (clear),
      .locked    (locked),
      .err       (err),
      .err_count (err_count)
   );

   prbs_checker #(.ERR_CNT_WIDTH(4)) dut_sat (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clear     (clear),
      .locked    (locked_s),
      .err       (err_s),
      .err_count (err_count_s)
   );

   function automatic logic [31:0] step(input logic [31:0] v);
      return {v[30:0], ^(v & TAP)};
   endfunction

   task automatic drive(input logic v, input logic [31:0] d, input logic c);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      clear    = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send_good();
      drive(1'b1, x, 1'b0);
      x = step(x);
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_rst    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      clear    = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         in_data  = $urandom;
         clear    = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n_checks++;
         if (locked !== 1'b0) begin $display("FAIL reset_locked: got %b want 0", locked); n_fail++; end
         n_checks++;
         if (err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err); n_fail++; end
         n_checks++;
         if (err_count !== 16'd0) begin $display("FAIL reset_cnt: got %0d want 0", err_count); n_fail++; end
      end
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
      n_rst    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h0, 1'b0);
         n_checks++;
         if (locked !== 1'b0 || err !== 1'b0) begin
            $display("FAIL zero_words: locked=%b err=%b want 0 0", locked, err); n_fail++;
         end
      end
   endtask

   task automatic test_lock();
      do_reset();
      x = SEED;
      for (int k = 1; k <= 7; k++) begin
         send_good();
         n_checks++;
         if (locked !== (k >= 5)) begin $display("FAIL lock_cont word %0d: locked=%b want %b", k, locked, (k >= 5)); n_fail++; end
         n_checks++;
         if (err !== 1'b0) begin $display("FAIL lock_cont_err word %0d: err=%b want 0", k, err); n_fail++; end
         n_checks++;
         if (locked_s !== (k >= 5)) begin $display("FAIL lock_cont_sat word %0d: locked=%b want %b", k, locked_s, (k >= 5)); n_fail++; end
      end
   endtask

   task automatic test_lock_toggle();
      int vc;
      do_reset();
      x  = SEED;
      vc = 0;
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 1) begin
            drive(1'b0, $urandom, 1'b0);
         end else begin
            send_good();
            vc++;
         end
         n_checks++;
         if (locked !== (vc >= 5)) begin $display("FAIL lock_toggle cycle %0d: locked=%b want %b", i, locked, (vc >= 5)); n_fail++; end
         n_checks++;
         if (err !== 1'b0) begin $display("FAIL lock_toggle_err cycle %0d: err=%b want 0", i, err); n_fail++; end
      end
   endtask

   task automatic test_single_error();
      drive(1'b1, x ^ 32'h1, 1'b0);
      x = step(x);
      n_checks++;
      if (err !== 1'b1) begin $display("FAIL single_err_pulse: err=%b want 1", err); n_fail++; end
      n_checks++;
      if (err_count !== 16'd1) begin $display("FAIL single_err_cnt: got %0d want 1", err_count); n_fail++; end
      n_checks++;
      if (locked !== 1'b1) begin $display("FAIL single_err_locked: got %b want 1", locked); n_fail++; end
      drive(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (err !== 1'b0) begin $display("FAIL single_err_idle: err=%b want 0", err); n_fail++; end
      for (int k = 0; k < 5; k++) begin
         send_good();
         n_checks++;
         if (err !== 1'b0 || locked !== 1'b1 || err_count !== 16'd1) begin
            $display("FAIL flywheel %0d: err=%b locked=%b cnt=%0d want 0 1 1", k, err, locked, err_count); n_fail++;
         end
      end
   endtask

   task automatic test_verify_reseed();
      logic [31:0] w;
      do_reset();
      x = SEED;
      for (int k = 0; k < 3; k++) send_good();
      w = 32'h12345678;
      drive(1'b1, w, 1'b0);
      x = step(w);
      n_checks++;
      if (locked !== 1'b0 || err !== 1'b0) begin $display("FAIL reseed_mismatch: locked=%b err=%b want 0 0", locked, err); n_fail++; end
      for (int k = 1; k <= 4; k++) begin
         send_good();
         n_checks++;
         if (locked !== (k == 4)) begin $display("FAIL reseed_lock match %0d: locked=%b want %b", k, locked, (k == 4)); n_fail++; end
      end
      do_reset();
      x = SEED;
      send_good();
      send_good();
      drive(1'b1, 32'h0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         send_good();
         n_checks++;
         if (locked !== (k == 5)) begin $display("FAIL zero_in_verify word %0d: locked=%b want %b", k, locked, (k == 5)); n_fail++; end
      end
   endtask

   task automatic test_loss();
      do_reset();
      x = SEED;
      for (int k = 0; k < 5; k++) send_good();
      n_checks++;
      if (locked !== 1'b1) begin $display("FAIL loss_prelock: locked=%b want 1", locked); n_fail++; end
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, ~x, 1'b0);
         x = step(x);
         n_checks++;
         if (err !== 1'b1) begin $display("FAIL loss_err %0d: err=%b want 1", k, err); n_fail++; end
         n_checks++;
         if (err_count !== 16'(k)) begin $display("FAIL loss_cnt %0d: got %0d want %0d", k, err_count, k); n_fail++; end
         n_checks++;
         if (locked !== (k < 4)) begin $display("FAIL loss_locked %0d: locked=%b want %b", k, locked, (k < 4)); n_fail++; end
      end
      for (int k = 1; k <= 5; k++) begin
         send_good();
         n_checks++;
         if (locked !== (k == 5)) begin $display("FAIL relock %0d: locked=%b want %b", k, locked, (k == 5)); n_fail++; end
         n_checks++;
         if (err !== 1'b0 || err_count !== 16'd4) begin $display("FAIL relock_cnt %0d: err=%b cnt=%0d want 0 4", k, err, err_count); n_fail++; end
      end
   endtask

   task automatic test_saturate();
      do_reset();
      x = SEED;
      for (int k = 0; k < 5; k++) send_good();
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, x ^ 32'h80000000, 1'b0);
         x = step(x);
         n_checks++;
         if (err_s !== 1'b1 || locked_s !== 1'b1) begin $display("FAIL sat_err %0d: err=%b locked=%b want 1 1", k, err_s, locked_s); n_fail++; end
         n_checks++;
         if (err_count_s !== ((k > 15) ? 4'd15 : 4'(k))) begin $display("FAIL sat_cnt %0d: got %0d want %0d", k, err_count_s, (k > 15) ? 15 : k); n_fail++; end
         n_checks++;
         if (err_count !== 16'(k)) begin $display("FAIL wide_cnt %0d: got %0d want %0d", k, err_count, k); n_fail++; end
         send_good();
         n_checks++;
         if (err_s !== 1'b0) begin $display("FAIL sat_gap %0d: err=%b want 0", k, err_s); n_fail++; end
      end
      drive(1'b1, x ^ 32'h1, 1'b1);
      x = step(x);
      clear = 1'b0;
      n_checks++;
      if (err !== 1'b1 || err_s !== 1'b1) begin $display("FAIL clear_err: err=%b err_s=%b want 1 1", err, err_s); n_fail++; end
      n_checks++;
      if (err_count !== 16'd0 || err_count_s !== 4'd0) begin $display("FAIL clear_cnt: got %0d %0d want 0 0", err_count, err_count_s); n_fail++; end
      n_checks++;
      if (locked !== 1'b1) begin $display("FAIL clear_locked: got %b want 1", locked); n_fail++; end
   endtask

   task automatic test_async_reset();
      drive(1'b1, x ^ 32'h1, 1'b0);
      x = step(x);
      n_checks++;
      if (err !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
         $display("FAIL async_pre: err=%b cnt=%0d locked=%b want 1 1 1", err, err_count, locked); n_fail++;
      end
      #2;
      n_rst = 1'b0;
      #1;
      n_checks++;
      if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0) begin
         $display("FAIL async_reset: locked=%b err=%b cnt=%0d want 0 0 0", locked, err, err_count); n_fail++;
      end
      n_checks++;
      if (locked_s !== 1'b0 || err_count_s !== 4'd0) begin $display("FAIL async_reset_sat: locked=%b cnt=%0d want 0 0", locked_s, err_count_s); n_fail++; end
      @(negedge clk);
      in_valid = 1'b0;
      n_rst    = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         send_good();
         n_checks++;
         if (locked !== (k == 5)) begin $display("FAIL async_relock %0d: locked=%b want %b", k, locked, (k == 5)); n_fail++; end
      end
   endtask

   initial begin
      in_valid = 1'b0;
      in_data  = '0;
      clear    = 1'b0;
      x        = SEED;
      test_reset();
      test_lock();
      test_lock_toggle();
      test_single_error();
      test_verify_reseed();
      test_loss();
      test_saturate();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
